cmac_tx_pkt_buffer: RTL and testbench
=====================================

// Module: cmac_tx_pkt_buffer
// PURPOSE
//  Store-and-forward packet FIFO between the ERNIC TX AXI-Stream output and the CMAC tx_axis port.
//  The CMAC flags underflow if tvalid drops inside a frame. This block releases a packet only once
//  its last beat has been written, so the CMAC always sees back-to-back beats within each frame.
//  Packets too large to fit in the buffer are discarded, and the discard is counted.
// PARAMETERS
//  DATA_WIDTH  512  tdata width; tkeep width is DATA_WIDTH/8
//  DEPTH_LOG2  6    buffer depth = 2**DEPTH_LOG2 beats (default 64 beats = 4096 B)
//  CNT_WIDTH   32   width of the statistics counters
// PORTS
//  clk            in   1             CMAC txusrclk2 domain; single clock
//  reset          in   1             asynchronous, active-high; drive from usr_tx_reset
//  s_axis_tdata   in   DATA_WIDTH    packet data from ERNIC
//  s_axis_tkeep   in   DATA_WIDTH/8  byte enables; contiguous from bit 0
//  s_axis_tvalid  in   1             input beat valid
//  s_axis_tlast   in   1             last beat of the packet
//  s_axis_tready  out  1             buffer accepts the beat
//  m_axis_tdata   out  DATA_WIDTH    to CMAC tx_axis_tdata
//  m_axis_tkeep   out  DATA_WIDTH/8  to CMAC tx_axis_tkeep
//  m_axis_tvalid  out  1             to CMAC tx_axis_tvalid
//  m_axis_tlast   out  1             to CMAC tx_axis_tlast
//  m_axis_tuser   out  1             tied 0; no error insertion
//  m_axis_tready  in   1             from CMAC tx_axis_tready
//  pkt_in_cnt     out  CNT_WIDTH     packets committed to the buffer
//  pkt_out_cnt    out  CNT_WIDTH     packets fully sent (tlast handshake on m_axis)
//  pkt_drop_cnt   out  CNT_WIDTH     oversize packets discarded
//  fifo_level     out  DEPTH_LOG2+1  beats held, including uncommitted beats
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, including s_axis_tready, all counters and fifo_level
//   - pointers cleared; drop state cleared
//   - s_axis_tready rises on the first clk edge after reset deasserts
//  Pointers (all DEPTH_LOG2+1 bits, MSB = wrap bit):
//   - wr_ptr: next write slot
//   - cm_ptr: commit pointer
//   - rd_ptr: next read slot
//   - full when wr_ptr - rd_ptr == 2**DEPTH_LOG2
//  Write side, states FILL / DROP:
//   - FILL: s_axis_tready = !full
//   - Accepted beat: stored, wr_ptr++.
//   - If the beat has tlast: cm_ptr <= wr_ptr+1 and pkt_in_cnt++ (same edge).
//   - FILL->DROP: full && cm_ptr == rd_ptr, i.e. the whole buffer holds one unfinished packet.
//     On entry, wr_ptr rewinds to cm_ptr.
//   - Full with committed data present: stall only (tready=0); no drop.
//   - DROP: s_axis_tready = 1; beats are discarded.
//   - DROP->FILL: on the tlast handshake; pkt_drop_cnt++ on that edge.
//  Read side:
//   - Output register is first-word-fall-through.
//   - A beat is readable when rd_ptr != cm_ptr.
//   - m_axis_tvalid rises at most 2 clk after the input tlast handshake (commit, then output load).
//   - Once m_axis_tvalid=1, the output holds stable until m_axis_tready=1.
//   - Within a packet, tvalid never drops, because all beats are already committed.
//   - Output runs at 1 beat/clk under continuous m_axis_tready.
//   - pkt_out_cnt++ on each m_axis tlast handshake.
//  Simultaneous read and write: legal every cycle; fifo_level = wr_ptr - rd_ptr, registered.
//  Counters wrap modulo 2**CNT_WIDTH.
//  A single-beat packet (tvalid with tlast) is valid.
//  A beat with tkeep=0 is passed through unchanged.
//  Reset mid-packet, either side:
//   - all content is lost; no partial packet is emitted after reset
//   - the upstream remainder of an interrupted packet is accepted as a new packet
//     (upstream resets with the same signal)
// TESTING
//  1. One 522 B packet: 9 beats, beat 9 tkeep=64'h3FF; m_tready=1.
//     Expect m_tvalid 2 clk after the s_axis tlast handshake, 9 contiguous beats, data identical,
//     pkt_in_cnt=pkt_out_cnt=1.
//  2. 1000 back-to-back 522 B packets with m_tready toggling at random.
//     Expect zero mismatches, no tvalid gap inside any frame, pkt_out_cnt=1000.
//  3. m_tready=0, then 7 x 9-beat packets.
//     Expect fifo_level=63. The 8th packet stalls with s_tready=0 after 1 beat (level 64).
//     After m_tready=1, all 8 packets are delivered intact.
//  4. 70-beat packet into an empty buffer (DEPTH_LOG2=6).
//     Expect DROP after 64 beats, remaining 6 beats absorbed, pkt_drop_cnt=1, no m_axis output.
//     A following 9-beat packet is delivered correctly.
//  5. Assert reset on beat 5 of 9 while a previous packet is mid-output.
//     Expect m_tvalid=0 and s_tready=0 while reset is high; counters and fifo_level=0.
//     Next full packet passes normally.

Source files
------------

// File: rtl/cmac_tx_pkt_buffer.sv
// Store-and-forward TX packet buffer between the ERNIC AXI-Stream output and the CMAC tx_axis port.
// A packet becomes visible on m_axis only after its last beat is written; oversize packets are dropped.
module cmac_tx_pkt_buffer #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG2 = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic [CNT_WIDTH-1:0]    pkt_in_cnt,
    output logic [CNT_WIDTH-1:0]    pkt_out_cnt,
    output logic [CNT_WIDTH-1:0]    pkt_drop_cnt,
    output logic [DEPTH_LOG2:0]     fifo_level
);
    localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
    localparam int DEPTH       = 2 ** DEPTH_LOG2;
    localparam int ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic [ENTRY_WIDTH-1:0] rd_entry;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] cm_ptr_q, cm_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] level_q;
    logic [0:0]          state_q, state_d;
    logic                ready_en_q;

    logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;

    logic [DEPTH_LOG2:0] used;
    logic                full;
    logic                in_ready;
    logic                in_fire;
    logic                out_fire;
    logic                wr_en;

    // Readiness is held low until the first edge after reset so upstream restarts cleanly.
    always_comb begin
        used     = wr_ptr_q - rd_ptr_q;
        full     = (used == FULL_LEVEL);
        in_ready = ready_en_q && ((state_q == ST_DROP) || !full);
        in_fire  = s_axis_tvalid && in_ready;
        out_fire = out_valid_q && m_axis_tready;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        in_cnt_d   = in_cnt_q;
        drop_cnt_d = drop_cnt_q;
        wr_en      = 1'b0;
        case (state_q)
            ST_FILL: begin
                // A buffer filled by one unfinished packet can never drain, so discard it.
                if (full && (cm_ptr_q == rd_ptr_q)) begin
                    state_d  = ST_DROP;
                    wr_ptr_d = cm_ptr_q;
                end else if (in_fire) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (s_axis_tlast) begin
                        cm_ptr_d = wr_ptr_q + 1'b1;
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (in_fire && s_axis_tlast) begin
                    state_d    = ST_FILL;
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (out_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign rd_entry = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];

    // The output register shows mem[rd_ptr]; its slot stays occupied until the beat is handed off.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_keep_d  = out_keep_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
        if ((!out_valid_q || out_fire) && (rd_ptr_d != cm_ptr_q)) begin
            out_valid_d                          = 1'b1;
            {out_last_d, out_keep_d, out_data_d} = rd_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= ST_FILL;
            ready_en_q  <= 1'b0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_keep_q  <= '0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= wr_ptr_d - rd_ptr_d;
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_keep_q  <= out_keep_d;
            out_data_q  <= out_data_d;
        end
    end

    assign s_axis_tready = in_ready;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tuser  = 1'b0;
    assign pkt_in_cnt    = in_cnt_q;
    assign pkt_out_cnt   = out_cnt_q;
    assign pkt_drop_cnt  = drop_cnt_q;
    assign fifo_level    = level_q;
endmodule

// File: tb/tb_cmac_tx_pkt_buffer.sv
// Randomised bench for cmac_tx_pkt_buffer: packets go through a queue-based reference model
// that commits whole packets of up to 64 beats and discards longer ones.
module tb_cmac_tx_pkt_buffer;
    localparam int DW      = 512;
    localparam int KW      = DW / 8;
    localparam int DL      = 6;
    localparam int CW      = 32;
    localparam int MAX_LEN = 2 ** DL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] sTdata = '0;
    logic [KW-1:0] sTkeep = '0;
    logic          sTvalid = 1'b0;
    logic          sTlast = 1'b0;
    logic          sTready;
    logic [DW-1:0] mTdata;
    logic [KW-1:0] mTkeep;
    logic          mTvalid;
    logic          mTlast;
    logic          mTuser;
    logic          mTready;
    logic [CW-1:0] pktInCnt;
    logic [CW-1:0] pktOutCnt;
    logic [CW-1:0] pktDropCnt;
    logic [DL:0]   fifoLevel;

    logic randomMode = 1'b0;
    logic fixedReady = 1'b0;
    logic randBit = 1'b0;

    int nChecks = 0;
    int nPass = 0;

    logic [DW-1:0] pktData [128];
    logic [KW-1:0] pktKeep [128];
    int            pktLen;

    logic [DW-1:0] expData [$];
    logic [KW:0]   expCtl [$];
    logic [DW-1:0] curData [$];
    logic [KW:0]   curCtl [$];
    int            modelIn = 0;
    int            modelOut = 0;
    int            modelDrop = 0;
    bit            outInFrame = 1'b0;

    cmac_tx_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .reset(reset),
        .s_axis_tdata(sTdata),
        .s_axis_tkeep(sTkeep),
        .s_axis_tvalid(sTvalid),
        .s_axis_tlast(sTlast),
        .s_axis_tready(sTready),
        .m_axis_tdata(mTdata),
        .m_axis_tkeep(mTkeep),
        .m_axis_tvalid(mTvalid),
        .m_axis_tlast(mTlast),
        .m_axis_tuser(mTuser),
        .m_axis_tready(mTready),
        .pkt_in_cnt(pktInCnt),
        .pkt_out_cnt(pktOutCnt),
        .pkt_drop_cnt(pktDropCnt),
        .fifo_level(fifoLevel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        randBit = 1'($urandom_range(0, 1));
    end

    assign mTready = randomMode ? randBit : fixedReady;

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    function automatic logic [DW-1:0] randWide();
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++) begin
            r[w*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic makePacket(input int len, input logic [KW-1:0] lastKeep);
        pktLen = len;
        for (int i = 0; i < len; i++) begin
            pktData[i] = randWide();
            pktKeep[i] = (i == len - 1) ? lastKeep : '1;
        end
    endtask

    // Drives beats first..lastIdx of the current packet back-to-back; caller sits at posedge+1.
    task automatic applyStimulus(input int first, input int lastIdx);
        bit accepted;
        int waitCnt;
        for (int i = first; i <= lastIdx; i++) begin
            sTdata  = pktData[i];
            sTkeep  = pktKeep[i];
            sTlast  = (i == pktLen - 1);
            sTvalid = 1'b1;
            accepted = 1'b0;
            waitCnt = 0;
            while (!accepted && waitCnt < 2000) begin
                @(negedge clk);
                accepted = sTready;
                @(posedge clk);
                #1;
                waitCnt++;
            end
            if (!accepted) begin
                checkOutput("sendTimeout", 0, 1);
                sTvalid = 1'b0;
                sTlast  = 1'b0;
                return;
            end
        end
        sTvalid = 1'b0;
        sTlast  = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expData.size() != 0 || mTvalid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            checkOutput("drainTimeout", 0, 1);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, ".pktInCnt"}, pktInCnt, modelIn);
        checkOutput({tag, ".pktOutCnt"}, pktOutCnt, modelOut);
        checkOutput({tag, ".pktDropCnt"}, pktDropCnt, modelDrop);
        checkOutput({tag, ".fifoLevel"}, fifoLevel, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".sTready"}, sTready, 0);
        checkOutput({tag, ".mTvalid"}, mTvalid, 0);
        checkOutput({tag, ".mTuser"}, mTuser, 0);
        checkOutput({tag, ".pktInCnt"}, pktInCnt, 0);
        checkOutput({tag, ".pktOutCnt"}, pktOutCnt, 0);
        checkOutput({tag, ".pktDropCnt"}, pktDropCnt, 0);
        checkOutput({tag, ".fifoLevel"}, fifoLevel, 0);
    endtask

    // Reference model: whole packets are committed if they fit the buffer, else discarded.
    task automatic monitorStep();
        if (reset) begin
            expData.delete();
            expCtl.delete();
            curData.delete();
            curCtl.delete();
            modelIn = 0;
            modelOut = 0;
            modelDrop = 0;
            outInFrame = 1'b0;
            return;
        end
        if (sTvalid && sTready) begin
            curData.push_back(sTdata);
            curCtl.push_back({sTlast, sTkeep});
            if (sTlast) begin
                if (curData.size() <= MAX_LEN) begin
                    foreach (curData[i]) begin
                        expData.push_back(curData[i]);
                        expCtl.push_back(curCtl[i]);
                    end
                    modelIn++;
                end else begin
                    modelDrop++;
                end
                curData.delete();
                curCtl.delete();
            end
        end
        if (outInFrame) begin
            checkOutput("tvalidGap", mTvalid, 1);
        end
        if (mTvalid && mTready) begin
            if (expData.size() == 0) begin
                checkOutput("unexpectedBeat", 1, 0);
            end else begin
                checkOutput("beatData", mTdata, expData.pop_front());
                checkOutput("beatCtl", {mTlast, mTkeep}, expCtl.pop_front());
            end
            outInFrame = !mTlast;
            if (mTlast) begin
                modelOut++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks passed %0d of %0d", nPass, nChecks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState("por");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("readyLowFirstCycle", sTready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("readyAfterReset", sTready, 1);
        @(posedge clk);
        #1;

        // Single 522 B packet and its commit-to-output latency
        fixedReady = 1'b1;
        makePacket(9, 64'h3FF);
        applyStimulus(0, 8);
        @(negedge clk);
        checkOutput("latencyEarly", mTvalid, 0);
        @(negedge clk);
        checkOutput("latency2clk", mTvalid, 1);
        @(posedge clk);
        #1;
        waitDrain(200);
        checkCounters("single");

        // 1000 back-to-back packets under random backpressure
        randomMode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            makePacket(9, 64'h3FF);
            applyStimulus(0, 8);
        end
        waitDrain(5000);
        checkCounters("stream");
        checkOutput("streamOutTotal", pktOutCnt, 1001);

        // Fill with 7 committed packets, 8th stalls at a full buffer
        randomMode = 1'b0;
        fixedReady = 1'b0;
        for (int p = 0; p < 7; p++) begin
            makePacket(9, 64'h3FF);
            applyStimulus(0, 8);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("level63", fifoLevel, 63);
        @(posedge clk);
        #1;
        makePacket(9, 64'h3FF);
        applyStimulus(0, 0);
        sTdata  = pktData[1];
        sTkeep  = pktKeep[1];
        sTvalid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("stallReady", sTready, 0);
        checkOutput("level64", fifoLevel, 64);
        @(posedge clk);
        #1;
        fixedReady = 1'b1;
        applyStimulus(1, 8);
        waitDrain(500);
        checkCounters("fullStall");

        // Oversize packet is dropped, the next packets still pass
        makePacket(70, 64'h3FF);
        applyStimulus(0, 63);
        @(negedge clk);
        checkOutput("levelAtDrop", fifoLevel, 64);
        checkOutput("readyAtDrop", sTready, 0);
        @(posedge clk);
        #1;
        applyStimulus(64, 69);
        waitDrain(200);
        checkCounters("oversize");
        checkOutput("dropCount", pktDropCnt, 1);
        makePacket(9, 64'h3FF);
        applyStimulus(0, 8);
        waitDrain(200);
        checkCounters("afterDrop");
        makePacket(1, '0);
        applyStimulus(0, 0);
        waitDrain(200);
        checkCounters("singleBeatKeep0");

        // Reset during input beat 5 while an earlier packet is still draining
        fixedReady = 1'b0;
        makePacket(9, 64'h3FF);
        applyStimulus(0, 8);
        randomMode = 1'b1;
        makePacket(9, 64'h3FF);
        applyStimulus(0, 3);
        sTdata  = pktData[4];
        sTkeep  = pktKeep[4];
        sTlast  = 1'b0;
        sTvalid = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        checkResetState("midReset");
        @(posedge clk);
        #1;
        @(negedge clk);
        checkResetState("midResetHeld");
        @(posedge clk);
        #1;
        reset      = 1'b0;
        sTvalid    = 1'b0;
        randomMode = 1'b0;
        fixedReady = 1'b1;
        @(posedge clk);
        #1;
        makePacket(9, 64'h3FF);
        applyStimulus(0, 8);
        waitDrain(200);
        checkCounters("afterReset");
        checkOutput("afterResetOut", pktOutCnt, 1);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
